// File: rtl/alu_stage_pkg.sv
// Shared widths and control-bus bit positions for the SimpleRisc EX stage.
package alu_stage_pkg;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 22;

   localparam int IDX_ST     = 0;
   localparam int IDX_LD     = 1;
   localparam int IDX_BEQ    = 2;
   localparam int IDX_BGT    = 3;
   localparam int IDX_RET    = 4;
   localparam int IDX_IMM    = 5;
   localparam int IDX_WB     = 6;
   localparam int IDX_UBR    = 7;
   localparam int IDX_CALL   = 8;
   localparam int IDX_ADD    = 9;
   localparam int IDX_SUB    = 10;
   localparam int IDX_CMP    = 11;
   localparam int IDX_MUL    = 12;
   localparam int IDX_DIV    = 13;
   localparam int IDX_MOD    = 14;
   localparam int IDX_LSL    = 15;
   localparam int IDX_LSR    = 16;
   localparam int IDX_ASR    = 17;
   localparam int IDX_OR     = 18;
   localparam int IDX_AND    = 19;
   localparam int IDX_NOT    = 20;
   localparam int IDX_MOV    = 21;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [CTRL_W-1:0] ctrl_t;
endpackage

// File: rtl/alu_stage_alu_core.sv
// Combinational SimpleRisc ALU: one-hot op select plus equality / signed-greater compare.
module alu_core
   import alu_stage_pkg::*;
(
   input  word_t a_i,
   input  word_t b_i,
   input  ctrl_t ctrl_i,
   output word_t result_o,
   output logic  eq_o,
   output logic  gt_o
);

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic [4:0] shamt;
   logic       div_zero;
   logic       div_ovf;
   word_t      sum;
   word_t      diff;
   word_t      prod;
   word_t      quot;
   word_t      rem;
   logic       unused_ctrl;

   assign a_s   = a_i;
   assign b_s   = b_i;
   assign shamt = b_i[4:0];
   assign sum   = a_i + b_i;
   assign diff  = a_i - b_i;
   assign prod  = a_i * b_i;

   assign div_zero = (b_i == '0);
   assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

   // The two corner cases are pinned explicitly so the result never depends on
   // how the divider treats a zero divisor or the INT_MIN / -1 overflow.
   always_comb begin
      quot = '0;
      rem  = a_i;
      if (div_zero) begin
         quot = '0;
         rem  = a_i;
      end else if (div_ovf) begin
         quot = a_i;
         rem  = '0;
      end else begin
         quot = word_t'(a_s / b_s);
         rem  = word_t'(a_s % b_s);
      end
   end

   always_comb begin
      result_o = '0;
      if (ctrl_i[IDX_ADD] || ctrl_i[IDX_LD] || ctrl_i[IDX_ST]) result_o = sum;
      else if (ctrl_i[IDX_SUB] || ctrl_i[IDX_CMP])             result_o = diff;
      else if (ctrl_i[IDX_MUL])                                result_o = prod;
      else if (ctrl_i[IDX_DIV])                                result_o = quot;
      else if (ctrl_i[IDX_MOD])                                result_o = rem;
      else if (ctrl_i[IDX_LSL])                                result_o = a_i << shamt;
      else if (ctrl_i[IDX_LSR])                                result_o = a_i >> shamt;
      else if (ctrl_i[IDX_ASR])                                result_o = word_t'(a_s >>> shamt);
      else if (ctrl_i[IDX_OR])                                 result_o = a_i | b_i;
      else if (ctrl_i[IDX_AND])                                result_o = a_i & b_i;
      else if (ctrl_i[IDX_NOT])                                result_o = ~b_i;
      else if (ctrl_i[IDX_MOV])                                result_o = b_i;
   end

   assign eq_o = (a_i == b_i);
   assign gt_o = (a_s > b_s);

   assign unused_ctrl = ^{ctrl_i[IDX_BEQ], ctrl_i[IDX_BGT], ctrl_i[IDX_RET], ctrl_i[IDX_IMM],
                          ctrl_i[IDX_WB], ctrl_i[IDX_UBR], ctrl_i[IDX_CALL]};

endmodule

// File: rtl/alu_stage.sv
// SimpleRisc EX stage: ALU, branch resolution toward IF, compare flags and EX/MA latch.
module alu_stage
   import alu_stage_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] input_EX_PC,
   input  logic [DATA_W-1:0] EX_branchTarget,
   input  logic [DATA_W-1:0] Operand_EX_A,
   input  logic [DATA_W-1:0] Operand_EX_B,
   input  logic [DATA_W-1:0] Operand_EX_2,
   input  logic [DATA_W-1:0] input_EX_IR,
   input  logic [CTRL_W-1:0] Input_EX_controlBus,
   output logic [DATA_W-1:0] EX_branchPC,
   output logic              EX_is_Branch_Taken,
   output logic [DATA_W-1:0] input_MA_PC,
   output logic [DATA_W-1:0] input_MA_ALU_Result,
   output logic [DATA_W-1:0] input_MA_op2,
   output logic [DATA_W-1:0] input_MA_IR,
   output logic [CTRL_W-1:0] input_MA_controlBus
);

   word_t alu_result;
   logic  alu_eq;
   logic  alu_gt;

   logic  flag_e_q;
   logic  flag_e_d;
   logic  flag_gt_q;
   logic  flag_gt_d;

   word_t pc_q;
   word_t result_q;
   word_t op2_q;
   word_t ir_q;
   ctrl_t ctrl_q;

   alu_core u_alu_core (
      .a_i      (Operand_EX_A),
      .b_i      (Operand_EX_B),
      .ctrl_i   (Input_EX_controlBus),
      .result_o (alu_result),
      .eq_o     (alu_eq),
      .gt_o     (alu_gt)
   );

   assign flag_e_d  = Input_EX_controlBus[IDX_CMP] ? alu_eq : flag_e_q;
   assign flag_gt_d = Input_EX_controlBus[IDX_CMP] ? alu_gt : flag_gt_q;

   // Branches read the registered flags, so a cmp immediately ahead of a beq/bgt
   // has already landed by the time the branch sits in EX.
   assign EX_is_Branch_Taken = Input_EX_controlBus[IDX_UBR]
                             | Input_EX_controlBus[IDX_RET]
                             | (Input_EX_controlBus[IDX_BEQ] & flag_e_q)
                             | (Input_EX_controlBus[IDX_BGT] & flag_gt_q);

   assign EX_branchPC = Input_EX_controlBus[IDX_RET] ? Operand_EX_A : EX_branchTarget;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_e_q  <= 1'b0;
         flag_gt_q <= 1'b0;
         pc_q      <= '0;
         result_q  <= '0;
         op2_q     <= '0;
         ir_q      <= '0;
         ctrl_q    <= '0;
      end else begin
         flag_e_q  <= flag_e_d;
         flag_gt_q <= flag_gt_d;
         pc_q      <= input_EX_PC;
         result_q  <= alu_result;
         op2_q     <= Operand_EX_2;
         ir_q      <= input_EX_IR;
         ctrl_q    <= Input_EX_controlBus;
      end
   end

   assign input_MA_PC         = pc_q;
   assign input_MA_ALU_Result = result_q;
   assign input_MA_op2        = op2_q;
   assign input_MA_IR         = ir_q;
   assign input_MA_controlBus = ctrl_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: vector table for single ops plus flag/branch and reset sequences.
module tb_alu_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ex_pc, ex_tgt, op_a, op_b, op_2, ex_ir;
   logic [21:0] ex_ctrl;
   logic [31:0] br_pc;
   logic        br_taken;
   logic [31:0] ma_pc, ma_res, ma_op2, ma_ir;
   logic [21:0] ma_ctrl;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_stage dut (
      .clk                 (clk),
      .reset               (reset),
      .input_EX_PC         (ex_pc),
      .EX_branchTarget     (ex_tgt),
      .Operand_EX_A        (op_a),
      .Operand_EX_B        (op_b),
      .Operand_EX_2        (op_2),
      .input_EX_IR         (ex_ir),
      .Input_EX_controlBus (ex_ctrl),
      .EX_branchPC         (br_pc),
      .EX_is_Branch_Taken  (br_taken),
      .input_MA_PC         (ma_pc),
      .input_MA_ALU_Result (ma_res),
      .input_MA_op2        (ma_op2),
      .input_MA_IR         (ma_ir),
      .input_MA_controlBus (ma_ctrl)
   );

   localparam logic [21:0] C_ST   = 22'h000001;
   localparam logic [21:0] C_LD   = 22'h000002;
   localparam logic [21:0] C_BEQ  = 22'h000004;
   localparam logic [21:0] C_BGT  = 22'h000008;
   localparam logic [21:0] C_RET  = 22'h000010;
   localparam logic [21:0] C_IMM  = 22'h000020;
   localparam logic [21:0] C_WB   = 22'h000040;
   localparam logic [21:0] C_UBR  = 22'h000080;
   localparam logic [21:0] C_CALL = 22'h000100;
   localparam logic [21:0] C_ADD  = 22'h000200;
   localparam logic [21:0] C_SUB  = 22'h000400;
   localparam logic [21:0] C_CMP  = 22'h000800;
   localparam logic [21:0] C_MUL  = 22'h001000;
   localparam logic [21:0] C_DIV  = 22'h002000;
   localparam logic [21:0] C_MOD  = 22'h004000;
   localparam logic [21:0] C_LSL  = 22'h008000;
   localparam logic [21:0] C_LSR  = 22'h010000;
   localparam logic [21:0] C_ASR  = 22'h020000;
   localparam logic [21:0] C_OR   = 22'h040000;
   localparam logic [21:0] C_AND  = 22'h080000;
   localparam logic [21:0] C_NOT  = 22'h100000;
   localparam logic [21:0] C_MOV  = 22'h200000;

   localparam logic [31:0] TGT = 32'h0000_2000;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] op2;
      logic [21:0] ctrl;
      logic [31:0] exp_res;
      logic        exp_taken;
      logic [31:0] exp_bpc;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] d2, input logic [31:0] ir,
                        input logic [21:0] ctrl);
      @(negedge clk);
      ex_pc = pc; ex_tgt = tgt; op_a = a; op_b = b; op_2 = d2; ex_ir = ir; ex_ctrl = ctrl;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic addv(input string n, input logic [31:0] a, input logic [31:0] b,
                       input logic [21:0] c, input logic [31:0] r, input logic t,
                       input logic [31:0] bpc);
      vec_t v;
      v.name = n; v.a = a; v.b = b; v.op2 = 32'hC0DE_0000 ^ a; v.ctrl = c;
      v.exp_res = r; v.exp_taken = t; v.exp_bpc = bpc;
      vecs.push_back(v);
   endtask

   initial begin
      addv("add",      32'd5,         32'd7,         C_ADD | C_WB,  32'd12,        1'b0, TGT);
      addv("sub_neg",  32'd5,         32'd7,         C_SUB | C_WB,  32'hFFFF_FFFE, 1'b0, TGT);
      addv("mul",      32'd6,         32'd7,         C_MUL | C_WB,  32'd42,        1'b0, TGT);
      addv("mul_wrap", 32'h0001_0000, 32'h0001_0003, C_MUL | C_WB,  32'h0003_0000, 1'b0, TGT);
      addv("add_wrap", 32'hFFFF_FFFF, 32'd2,         C_ADD | C_WB,  32'd1,         1'b0, TGT);
      addv("div_neg",  32'hFFFF_FFF9, 32'd2,         C_DIV | C_WB,  32'hFFFF_FFFD, 1'b0, TGT);
      addv("mod_neg",  32'hFFFF_FFF9, 32'd2,         C_MOD | C_WB,  32'hFFFF_FFFF, 1'b0, TGT);
      addv("div_pos",  32'd100,       32'd7,         C_DIV | C_WB,  32'd14,        1'b0, TGT);
      addv("mod_pos",  32'd100,       32'd7,         C_MOD | C_WB,  32'd2,         1'b0, TGT);
      addv("div_z",    32'd7,         32'd0,         C_DIV | C_WB,  32'd0,         1'b0, TGT);
      addv("mod_z",    32'd7,         32'd0,         C_MOD | C_WB,  32'd7,         1'b0, TGT);
      addv("div_ovf",  32'h8000_0000, 32'hFFFF_FFFF, C_DIV | C_WB,  32'h8000_0000, 1'b0, TGT);
      addv("mod_ovf",  32'h8000_0000, 32'hFFFF_FFFF, C_MOD | C_WB,  32'd0,         1'b0, TGT);
      addv("lsl",      32'd1,         32'd35,        C_LSL | C_WB,  32'd8,         1'b0, TGT);
      addv("lsr",      32'hF000_0000, 32'd4,         C_LSR | C_WB,  32'h0F00_0000, 1'b0, TGT);
      addv("asr",      32'hF000_0000, 32'd4,         C_ASR | C_WB,  32'hFF00_0000, 1'b0, TGT);
      addv("asr_pos",  32'h7000_0000, 32'd4,         C_ASR | C_WB,  32'h0700_0000, 1'b0, TGT);
      addv("or",       32'h0000_F0F0, 32'h0000_0F0F, C_OR  | C_WB,  32'h0000_FFFF, 1'b0, TGT);
      addv("and",      32'h0000_FF00, 32'h0000_0FF0, C_AND | C_WB,  32'h0000_0F00, 1'b0, TGT);
      addv("not",      32'h1234_5678, 32'h0000_0000, C_NOT | C_WB,  32'hFFFF_FFFF, 1'b0, TGT);
      addv("mov",      32'h1234_5678, 32'h0000_1234, C_MOV | C_WB,  32'h0000_1234, 1'b0, TGT);
      addv("ld",       32'h0000_0100, 32'd4,         C_LD | C_IMM | C_WB, 32'h0000_0104, 1'b0, TGT);
      addv("st",       32'h0000_0200, 32'd8,         C_ST | C_IMM,  32'h0000_0208, 1'b0, TGT);
      addv("nop",      32'd5,         32'd7,         22'h0,         32'd0,         1'b0, TGT);
      addv("ret",      32'h0000_0100, 32'd0,         C_RET,         32'd0,         1'b1, 32'h0000_0100);
      addv("call",     32'h0000_0300, 32'd0,         C_UBR | C_CALL | C_WB, 32'd0, 1'b1, TGT);
      addv("b",        32'h0000_0300, 32'd0,         C_UBR,         32'd0,         1'b1, TGT);

      reset = 1'b1;
      ex_pc = 32'h1111_1111; ex_tgt = TGT; op_a = 32'd1; op_b = 32'd2;
      op_2 = 32'h3333_3333; ex_ir = 32'h4444_4444; ex_ctrl = C_ADD;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_pc",   ma_pc,  32'd0);
      chk("rst_res",  ma_res, 32'd0);
      chk("rst_op2",  ma_op2, 32'd0);
      chk("rst_ir",   ma_ir,  32'd0);
      chk("rst_ctrl", {10'd0, ma_ctrl}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         logic [31:0] pc, ir;
         pc = 32'h0000_1000 + 32'(i * 4);
         ir = 32'hA500_0000 ^ 32'(i);
         drive(pc, TGT, vecs[i].a, vecs[i].b, vecs[i].op2, ir, vecs[i].ctrl);
         chk({vecs[i].name, "_taken"}, {31'd0, br_taken}, {31'd0, vecs[i].exp_taken});
         chk({vecs[i].name, "_bpc"}, br_pc, vecs[i].exp_bpc);
         step();
         chk({vecs[i].name, "_res"},  ma_res, vecs[i].exp_res);
         chk({vecs[i].name, "_pc"},   ma_pc,  pc);
         chk({vecs[i].name, "_ir"},   ma_ir,  ir);
         chk({vecs[i].name, "_op2"},  ma_op2, vecs[i].op2);
         chk({vecs[i].name, "_ctrl"}, {10'd0, ma_ctrl}, {10'd0, vecs[i].ctrl});
      end

      // cmp equal, then an unrelated op, then beq: flags must persist
      drive(32'h500, 32'h40, 32'd9, 32'd9, 32'd0, 32'h1, C_CMP);
      step();
      chk("cmp_eq_res", ma_res, 32'd0);
      drive(32'h504, 32'h40, 32'd1, 32'd1, 32'd0, 32'h2, C_BEQ);
      chk("beq_eq_taken", {31'd0, br_taken}, 32'd1);
      chk("beq_eq_bpc", br_pc, 32'h40);
      step();
      drive(32'h508, 32'h40, 32'd5, 32'd7, 32'd0, 32'h3, C_ADD);
      step();
      drive(32'h50C, 32'h44, 32'd0, 32'd0, 32'd0, 32'h4, C_BEQ);
      chk("beq_hold_taken", {31'd0, br_taken}, 32'd1);
      chk("beq_hold_bpc", br_pc, 32'h44);
      step();

      drive(32'h510, 32'h40, 32'd3, 32'd9, 32'd0, 32'h5, C_CMP);
      step();
      chk("cmp_ne_res", ma_res, 32'hFFFF_FFFA);
      drive(32'h514, 32'h40, 32'd0, 32'd0, 32'd0, 32'h6, C_BEQ);
      chk("beq_ne_taken", {31'd0, br_taken}, 32'd0);
      step();
      drive(32'h518, 32'h40, 32'd0, 32'd0, 32'd0, 32'h7, C_BGT);
      chk("bgt_3_9_taken", {31'd0, br_taken}, 32'd0);
      step();

      drive(32'h520, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8, C_CMP);
      step();
      drive(32'h524, 32'h80, 32'd0, 32'd0, 32'd0, 32'h9, C_BGT);
      chk("bgt_m1_1_taken", {31'd0, br_taken}, 32'd0);
      step();
      drive(32'h528, 32'h80, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'hA, C_CMP);
      step();
      drive(32'h52C, 32'h80, 32'd0, 32'd0, 32'd0, 32'hB, C_BGT);
      chk("bgt_1_m1_taken", {31'd0, br_taken}, 32'd1);
      chk("bgt_1_m1_bpc", br_pc, 32'h80);
      drive(32'h530, 32'h80, 32'd0, 32'd0, 32'd0, 32'hC, C_BEQ);
      chk("beq_1_m1_taken", {31'd0, br_taken}, 32'd0);
      step();

      // reset in the middle of a cycle with E set and a live instruction in MA
      drive(32'h600, 32'h40, 32'd9, 32'd9, 32'd0, 32'hD, C_CMP);
      step();
      drive(32'h604, 32'h40, 32'd5, 32'd7, 32'h77, 32'hE, C_ADD | C_WB);
      step();
      chk("pre_rst_res", ma_res, 32'd12);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_pc",   ma_pc,  32'd0);
      chk("mid_rst_res",  ma_res, 32'd0);
      chk("mid_rst_op2",  ma_op2, 32'd0);
      chk("mid_rst_ir",   ma_ir,  32'd0);
      chk("mid_rst_ctrl", {10'd0, ma_ctrl}, 32'd0);
      op_a = 32'h0000_0ABC; ex_ctrl = C_RET;
      #1;
      chk("rst_ret_taken", {31'd0, br_taken}, 32'd1);
      chk("rst_ret_bpc", br_pc, 32'h0000_0ABC);
      @(negedge clk);
      reset = 1'b0;
      drive(32'h608, 32'h40, 32'd0, 32'd0, 32'd0, 32'hF, C_BEQ);
      chk("post_rst_beq", {31'd0, br_taken}, 32'd0);
      step();
      chk("post_rst_ctrl", {10'd0, ma_ctrl}, {10'd0, C_BEQ});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
